// File: rtl/sd_block_responder.sv
// ============================================================================
// Module   : sd_block_responder
// Purpose  : RAM-backed stand-in for an SD host plus card on the sdspihost
//            level/busy block interface (init, block read, block write).
// Revision : 1.0
// ============================================================================
`default_nettype none

module sd_block_responder #(
  parameter logic [31:0] BASE_BLOCK  = 32'h0010_0000,
  parameter int unsigned NBLOCKS     = 4,
  parameter int unsigned INIT_CYCLES = 16,
  parameter int unsigned BLOCK_LAT   = 8,
  parameter int unsigned BYTE_LAT    = 4,
  parameter int unsigned COMMIT_LAT  = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        spi_rst_i,
  input  logic        spi_r_block_i,
  input  logic        spi_r_byte_i,
  input  logic        spi_r_multi_block_i,
  input  logic        spi_w_block_i,
  input  logic        spi_w_byte_i,
  input  logic [31:0] spi_block_addr_i,
  input  logic [7:0]  spi_data_in_i,
  output logic        spi_busy_o,
  output logic [7:0]  spi_data_out_o,
  output logic        spi_err_o,
  output logic        spi_crc_err_o
);

  localparam int unsigned MAX_A   = (INIT_CYCLES > BLOCK_LAT) ? INIT_CYCLES : BLOCK_LAT;
  localparam int unsigned MAX_B   = (BYTE_LAT > COMMIT_LAT) ? BYTE_LAT : COMMIT_LAT;
  localparam int unsigned MAX_LAT = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned CW      = $clog2(MAX_LAT) + 1;
  localparam int unsigned BLW     = (NBLOCKS > 1) ? $clog2(NBLOCKS) : 1;
  localparam int unsigned AW      = $clog2(NBLOCKS) + 9;
  localparam int unsigned DEPTH   = NBLOCKS * 512;

  typedef enum logic [3:0] {
    S_UNINIT    = 4'd0,
    S_INIT      = 4'd1,
    S_IDLE      = 4'd2,
    S_RD_OPEN   = 4'd3,
    S_RD_READY  = 4'd4,
    S_RD_BYTE   = 4'd5,
    S_WR_OPEN   = 4'd6,
    S_WR_READY  = 4'd7,
    S_WR_BYTE   = 4'd8,
    S_WR_COMMIT = 4'd9
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [9:0]     idx_q, idx_d;
  logic [BLW-1:0] blk_q, blk_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           err_q, err_d;
  logic [7:0]     dout_q, dout_d;
  logic [7:0]     ram_q;
  logic [7:0]     mem_q [DEPTH];
  logic           we;
  logic [31:0]    blk_off;
  logic           open_valid;
  logic [AW-1:0]  rd_addr, wr_addr;
  logic [7:0]     rd_byte;

  function automatic logic lat_done(input logic [CW-1:0] cnt, input int unsigned lat);
    return cnt == CW'(lat - 1);
  endfunction

  assign blk_off    = spi_block_addr_i - BASE_BLOCK;
  assign open_valid = blk_off < 32'(NBLOCKS);
  // Out-of-range sessions and bytes past 511 (CRC/pad) read as FF.
  assign rd_byte    = (valid_q && !idx_q[9]) ? ram_q : 8'hFF;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    blk_d   = blk_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    err_d   = err_q;
    dout_d  = dout_q;
    we      = 1'b0;
    case (state_q)
      S_UNINIT: begin
        if (spi_rst_i) begin
          state_d = S_INIT;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_INIT: begin
        if (lat_done(cnt_q, INIT_CYCLES)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      S_IDLE: begin
        if (spi_rst_i) begin
          state_d = S_INIT;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else if (spi_r_multi_block_i) begin
          err_d = 1'b1;
        end else if (spi_r_block_i || spi_w_block_i) begin
          state_d = spi_r_block_i ? S_RD_OPEN : S_WR_OPEN;
          blk_d   = BLW'(blk_off);
          valid_d = open_valid;
          err_d   = !open_valid;
          idx_d   = '0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_RD_OPEN: begin
        if (lat_done(cnt_q, BLOCK_LAT)) begin
          state_d = S_RD_READY;
          busy_d  = 1'b0;
          dout_d  = rd_byte;
        end
      end
      S_RD_READY: begin
        if (!spi_r_block_i) begin
          state_d = S_IDLE;
        end else if (spi_r_byte_i) begin
          state_d = S_RD_BYTE;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_RD_BYTE: begin
        if (lat_done(cnt_q, BYTE_LAT)) begin
          state_d = S_RD_READY;
          busy_d  = 1'b0;
          dout_d  = rd_byte;
          idx_d   = (idx_q == 10'h3FF) ? idx_q : idx_q + 10'd1;
        end
      end
      S_WR_OPEN: begin
        if (lat_done(cnt_q, BLOCK_LAT)) begin
          state_d = S_WR_READY;
          busy_d  = 1'b0;
        end
      end
      S_WR_READY: begin
        if (!spi_w_block_i) begin
          state_d = S_WR_COMMIT;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end else if (spi_w_byte_i) begin
          state_d = S_WR_BYTE;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      S_WR_BYTE: begin
        if (lat_done(cnt_q, BYTE_LAT)) begin
          state_d = S_WR_READY;
          busy_d  = 1'b0;
          we      = valid_q && !idx_q[9];
          idx_d   = (idx_q == 10'h3FF) ? idx_q : idx_q + 10'd1;
        end
      end
      S_WR_COMMIT: begin
        if (lat_done(cnt_q, COMMIT_LAT)) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = S_UNINIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_UNINIT;
      cnt_q   <= '0;
      idx_q   <= '0;
      blk_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      dout_q  <= 8'hFF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      blk_q   <= blk_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      dout_q  <= dout_d;
    end
  end

  // Read address follows the next-state index so ram_q always holds the
  // byte at the current index, even with single-cycle latencies.
  assign rd_addr = (AW'(blk_d) << 9) | AW'(idx_d[8:0]);
  assign wr_addr = (AW'(blk_q) << 9) | AW'(idx_q[8:0]);

  always_ff @(posedge clk_i) begin
    if (we) begin
      mem_q[wr_addr] <= spi_data_in_i;
    end
    ram_q <= mem_q[rd_addr];
  end

  assign spi_busy_o     = busy_q;
  assign spi_data_out_o = dout_q;
  assign spi_err_o      = err_q;
  assign spi_crc_err_o  = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_sd_block_responder.sv
// ============================================================================
// Module   : tb_sd_block_responder
// Purpose  : Directed self-checking bench for sd_block_responder.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sd_block_responder;

  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        spi_rst_i = 1'b0;
  logic        spi_r_block_i = 1'b0;
  logic        spi_r_byte_i = 1'b0;
  logic        spi_r_multi_block_i = 1'b0;
  logic        spi_w_block_i = 1'b0;
  logic        spi_w_byte_i = 1'b0;
  logic [31:0] spi_block_addr_i = 32'h0;
  logic [7:0]  spi_data_in_i = 8'h0;
  logic        spi_busy_o;
  logic [7:0]  spi_data_out_o;
  logic        spi_err_o;
  logic        spi_crc_err_o;

  int n_checks = 0;
  int n_fail   = 0;

  sd_block_responder dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .spi_rst_i           (spi_rst_i),
    .spi_r_block_i       (spi_r_block_i),
    .spi_r_byte_i        (spi_r_byte_i),
    .spi_r_multi_block_i (spi_r_multi_block_i),
    .spi_w_block_i       (spi_w_block_i),
    .spi_w_byte_i        (spi_w_byte_i),
    .spi_block_addr_i    (spi_block_addr_i),
    .spi_data_in_i       (spi_data_in_i),
    .spi_busy_o          (spi_busy_o),
    .spi_data_out_o      (spi_data_out_o),
    .spi_err_o           (spi_err_o),
    .spi_crc_err_o       (spi_crc_err_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Byte patterns: 0 = AA BB CC DD then (i-1), 1 = i[7:0], 2 = 11*(i+1),
  // 3 = 77, 4 = 99, anything else reads as FF.
  function automatic logic [7:0] gen(input int mode, input int i);
    logic [31:0] sig;
    sig = 32'hAABBCCDD;
    case (mode)
      0: return (i < 4) ? sig[31-8*i -: 8] : 8'(i - 1);
      1: return 8'(i);
      2: return 8'(17 * (i + 1));
      3: return 8'h77;
      4: return 8'h99;
      default: return 8'hFF;
    endcase
  endfunction

  // Counts busy cycles from the current negedge; gives up after 200.
  task automatic wait_busy(output int n);
    n = 0;
    while (spi_busy_o && n < 200) begin
      n++;
      @(negedge clk_i);
    end
  endtask

  task automatic write_session(input logic [31:0] addr, input int nbytes, input int mode,
                               input logic exp_err);
    int n;
    spi_block_addr_i = addr;
    spi_w_block_i    = 1'b1;
    @(negedge clk_i);
    wait_busy(n);
    chk_eq("wr_open_busy", n, 8);
    chk_eq("wr_open_err", spi_err_o, exp_err);
    for (int i = 0; i < nbytes; i++) begin
      spi_data_in_i = gen(mode, i);
      spi_w_byte_i  = 1'b1;
      @(negedge clk_i);
      spi_w_byte_i  = 1'b0;
      wait_busy(n);
      chk_eq("wr_byte_busy", n, 4);
    end
    spi_w_block_i = 1'b0;
    @(negedge clk_i);
    wait_busy(n);
    chk_eq("wr_commit_busy", n, 32);
  endtask

  task automatic read_session(input logic [31:0] addr, input int nbytes, input int mode,
                              input logic exp_err);
    int n;
    logic [7:0] e;
    spi_block_addr_i = addr;
    spi_r_block_i    = 1'b1;
    @(negedge clk_i);
    wait_busy(n);
    chk_eq("rd_open_busy", n, 8);
    chk_eq("rd_open_err", spi_err_o, exp_err);
    e = gen(mode, 0);
    chk_eq("rd_preview", spi_data_out_o, e);
    for (int i = 0; i < nbytes; i++) begin
      spi_r_byte_i = 1'b1;
      @(negedge clk_i);
      spi_r_byte_i = 1'b0;
      wait_busy(n);
      chk_eq("rd_byte_busy", n, 4);
      e = (i >= 512) ? 8'hFF : gen(mode, i);
      chk_eq($sformatf("rd_byte[%0d]", i), spi_data_out_o, e);
    end
    spi_r_block_i = 1'b0;
    @(negedge clk_i);
  endtask

  initial begin
    int n;
    int rises;
    logic prev;

    repeat (3) @(negedge clk_i);
    chk_eq("rst_busy", spi_busy_o, 1'b0);
    chk_eq("rst_dout", spi_data_out_o, 8'hFF);
    chk_eq("rst_err", spi_err_o, 1'b0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Block commands are ignored before init.
    spi_block_addr_i = BASE;
    spi_r_block_i    = 1'b1;
    repeat (4) @(negedge clk_i);
    chk_eq("uninit_busy", spi_busy_o, 1'b0);
    spi_r_block_i = 1'b0;
    @(negedge clk_i);

    spi_rst_i = 1'b1;
    @(negedge clk_i);
    spi_rst_i = 1'b0;
    wait_busy(n);
    chk_eq("init_busy", n, 16);
    chk_eq("crc_err", spi_crc_err_o, 1'b0);

    write_session(BASE + 0, 512, 0, 1'b0);
    write_session(BASE + 2, 4, 2, 1'b0);

    // Held w_byte on block 3: one store every BYTE_LAT+1 cycles.
    spi_block_addr_i = BASE + 3;
    spi_w_block_i    = 1'b1;
    @(negedge clk_i);
    wait_busy(n);
    spi_data_in_i = 8'h77;
    spi_w_byte_i  = 1'b1;
    rises = 0;
    prev  = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk_i);
      if (spi_busy_o && !prev) rises++;
      prev = spi_busy_o;
    end
    spi_w_byte_i = 1'b0;
    chk_eq("held_wbyte_stores", rises, 4);
    spi_w_block_i = 1'b0;
    @(negedge clk_i);
    wait_busy(n);
    chk_eq("held_commit_busy", n, 32);

    write_session(BASE + 1, 516, 1, 1'b0);

    read_session(BASE + 0, 513, 0, 1'b0);
    read_session(BASE + 1, 512, 1, 1'b0);
    read_session(BASE + 2, 4, 2, 1'b0);
    read_session(BASE + 3, 4, 3, 1'b0);

    // Out-of-range block: error flag, FF reads, discarded writes.
    read_session(32'h000F_FFFF, 3, 5, 1'b1);
    write_session(32'h000F_FFFF, 4, 4, 1'b1);
    read_session(BASE + 3, 4, 3, 1'b0);

    spi_r_multi_block_i = 1'b1;
    @(negedge clk_i);
    spi_r_multi_block_i = 1'b0;
    @(negedge clk_i);
    chk_eq("multi_err", spi_err_o, 1'b1);
    chk_eq("multi_busy", spi_busy_o, 1'b0);

    // Session flag dropped mid byte-op: op completes, then IDLE.
    spi_block_addr_i = BASE;
    spi_r_block_i    = 1'b1;
    @(negedge clk_i);
    wait_busy(n);
    chk_eq("valid_open_clears_err", spi_err_o, 1'b0);
    spi_r_byte_i = 1'b1;
    @(negedge clk_i);
    spi_r_byte_i  = 1'b0;
    spi_r_block_i = 1'b0;
    wait_busy(n);
    chk_eq("drop_rbyte_busy", n, 4);
    chk_eq("drop_rbyte_data", spi_data_out_o, 8'hAA);
    @(negedge clk_i);
    spi_r_byte_i = 1'b1;
    @(negedge clk_i);
    spi_r_byte_i = 1'b0;
    @(negedge clk_i);
    chk_eq("idle_ignores_rbyte", spi_busy_o, 1'b0);

    // Asynchronous reset in the middle of a session.
    spi_block_addr_i = 32'h000F_FFFF;
    spi_r_block_i    = 1'b1;
    @(negedge clk_i);
    chk_eq("pre_arst_busy", spi_busy_o, 1'b1);
    rst_ni = 1'b0;
    #1;
    chk_eq("arst_busy", spi_busy_o, 1'b0);
    chk_eq("arst_dout", spi_data_out_o, 8'hFF);
    chk_eq("arst_err", spi_err_o, 1'b0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (3) @(negedge clk_i);
    chk_eq("arst_uninit_busy", spi_busy_o, 1'b0);
    spi_r_block_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
